snitch_icache_miss_handler: RTL



---
 rtl/snitch_icache_pkg.sv | 24 ++
 rtl/snitch_icache_miss_handler_if.sv | 84 ++++++++
 rtl/lzc.sv | 26 ++
 rtl/snitch_icache_miss_handler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/snitch_icache_pkg.sv
// Shared types and default geometry for the instruction-cache miss path.
package snitch_icache_pkg;

   localparam int unsigned DEFAULT_FETCH_AW      = 32;
   localparam int unsigned DEFAULT_LINE_WIDTH    = 128;
   localparam int unsigned DEFAULT_LINE_ALIGN    = 4;
   localparam int unsigned DEFAULT_COUNT_ALIGN   = 6;
   localparam int unsigned DEFAULT_SET_ALIGN     = 1;
   localparam int unsigned DEFAULT_ID_WIDTH      = 4;
   localparam int unsigned DEFAULT_PENDING_COUNT = 2;

   // Line address is the fetch address with the in-line byte offset dropped.
   localparam int unsigned PEND_LINE_WIDTH = DEFAULT_FETCH_AW - DEFAULT_LINE_ALIGN;

   // One outstanding miss: the line it refills, the set chosen as victim at
   // allocation, and the OR of every requester waiting on that line.
   typedef struct packed {
      logic                             valid;
      logic [PEND_LINE_WIDTH-1:0]       line;
      logic [DEFAULT_SET_ALIGN-1:0]     set;
      logic [DEFAULT_ID_WIDTH-1:0]      idmask;
   } pending_t;

endpackage

// File: rtl/snitch_icache_miss_handler_if.sv
// Bus bundle around the miss handler: lookup in, response out, refill
// request/response and lookup write-back. master = miss handler side.
interface snitch_icache_miss_handler_if
   import snitch_icache_pkg::*;
#(
   parameter int unsigned FETCH_AW      = DEFAULT_FETCH_AW,
   parameter int unsigned LINE_WIDTH    = DEFAULT_LINE_WIDTH,
   parameter int unsigned LINE_ALIGN    = DEFAULT_LINE_ALIGN,
   parameter int unsigned COUNT_ALIGN   = DEFAULT_COUNT_ALIGN,
   parameter int unsigned SET_ALIGN     = DEFAULT_SET_ALIGN,
   parameter int unsigned TAG_WIDTH     = FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
   parameter int unsigned ID_WIDTH      = DEFAULT_ID_WIDTH,
   parameter int unsigned PENDING_COUNT = DEFAULT_PENDING_COUNT
);
   localparam int unsigned PID_WIDTH = $clog2(PENDING_COUNT);

   logic                   flush_valid_i;
   logic                   flush_ready_o;

   logic [FETCH_AW-1:0]    in_addr_i;
   logic [ID_WIDTH-1:0]    in_id_i;
   logic [SET_ALIGN-1:0]   in_set_i;
   logic                   in_hit_i;
   logic                   in_error_i;
   logic [LINE_WIDTH-1:0]  in_data_i;
   logic                   in_valid_i;
   logic                   in_ready_o;

   logic [LINE_WIDTH-1:0]  rsp_data_o;
   logic                   rsp_error_o;
   logic [ID_WIDTH-1:0]    rsp_id_o;
   logic                   rsp_valid_o;
   logic                   rsp_ready_i;

   logic [FETCH_AW-1:0]    refill_addr_o;
   logic [PID_WIDTH-1:0]   refill_pid_o;
   logic                   refill_valid_o;
   logic                   refill_ready_i;

   logic [LINE_WIDTH-1:0]  refill_data_i;
   logic                   refill_error_i;
   logic [PID_WIDTH-1:0]   refill_pid_i;
   logic                   refill_valid_i;
   logic                   refill_ready_o;

   logic [COUNT_ALIGN-1:0] write_addr_o;
   logic [SET_ALIGN-1:0]   write_set_o;
   logic [TAG_WIDTH-1:0]   write_tag_o;
   logic [LINE_WIDTH-1:0]  write_data_o;
   logic                   write_error_o;
   logic                   write_valid_o;
   logic                   write_ready_i;

   modport master (
      input  flush_valid_i,
      output flush_ready_o,
      input  in_addr_i, in_id_i, in_set_i, in_hit_i, in_error_i, in_data_i, in_valid_i,
      output in_ready_o,
      output rsp_data_o, rsp_error_o, rsp_id_o, rsp_valid_o,
      input  rsp_ready_i,
      output refill_addr_o, refill_pid_o, refill_valid_o,
      input  refill_ready_i,
      input  refill_data_i, refill_error_i, refill_pid_i, refill_valid_i,
      output refill_ready_o,
      output write_addr_o, write_set_o, write_tag_o, write_data_o, write_error_o, write_valid_o,
      input  write_ready_i
   );

   modport slave (
      output flush_valid_i,
      input  flush_ready_o,
      output in_addr_i, in_id_i, in_set_i, in_hit_i, in_error_i, in_data_i, in_valid_i,
      input  in_ready_o,
      input  rsp_data_o, rsp_error_o, rsp_id_o, rsp_valid_o,
      output rsp_ready_i,
      input  refill_addr_o, refill_pid_o, refill_valid_o,
      output refill_ready_i,
      output refill_data_i, refill_error_i, refill_pid_i, refill_valid_i,
      input  refill_ready_o,
      input  write_addr_o, write_set_o, write_tag_o, write_data_o, write_error_o, write_valid_o,
      output write_ready_i
   );

endinterface

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=0 counts trailing zeros (index of the
// lowest set bit), MODE=1 counts leading zeros. cnt_o is 0 when empty_o.
module lzc #(
   parameter  int unsigned WIDTH     = 2,
   parameter  bit          MODE      = 1'b0,
   localparam int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0]     in_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 empty_o
);

   // Priority scan; the last hit in scan order is the one that wins.
   always_comb begin
      cnt_o = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (!MODE) begin
            if (in_i[WIDTH-1-i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
         end else begin
            if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
         end
      end
      empty_o = ~|in_i;
   end

endmodule

// File: rtl/snitch_icache_miss_handler.sv
// Miss handler behind the icache lookup: passes hits through, merges misses
// into a small pending table, issues one refill per line and writes the
// returned line back while answering all merged requesters.
module snitch_icache_miss_handler
   import snitch_icache_pkg::*;
#(
   parameter int unsigned FETCH_AW      = DEFAULT_FETCH_AW,
   parameter int unsigned LINE_WIDTH    = DEFAULT_LINE_WIDTH,
   parameter int unsigned LINE_ALIGN    = DEFAULT_LINE_ALIGN,
   parameter int unsigned COUNT_ALIGN   = DEFAULT_COUNT_ALIGN,
   parameter int unsigned SET_ALIGN     = DEFAULT_SET_ALIGN,
   parameter int unsigned TAG_WIDTH     = FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
   parameter int unsigned ID_WIDTH      = DEFAULT_ID_WIDTH,
   parameter int unsigned PENDING_COUNT = DEFAULT_PENDING_COUNT
) (
   input logic                          clk_i,
   input logic                          rst_ni,
   snitch_icache_miss_handler_if.master bus
);

   localparam int unsigned LINE_AW   = FETCH_AW - LINE_ALIGN;
   localparam int unsigned PID_WIDTH = $clog2(PENDING_COUNT);

   pending_t                 pend_q [PENDING_COUNT];
   logic [PENDING_COUNT-1:0] pend_valid;
   logic [SET_ALIGN-1:0]     victim_q;

   logic                     refill_valid_q;
   logic [LINE_AW-1:0]       refill_line_q;
   logic [PID_WIDTH-1:0]     refill_pid_q;

   logic [LINE_AW-1:0]       in_line;
   logic                     match;
   logic [PID_WIDTH-1:0]     match_idx;
   logic [PID_WIDTH-1:0]     free_idx;
   logic                     no_free;
   pending_t                 cpl;

   logic                     complete_en;
   logic                     merge_en;
   logic                     alloc_en;
   logic                     flush_fire;

   logic [LINE_WIDTH-1:0]    rsp_data;
   logic [ID_WIDTH-1:0]      rsp_id;
   logic                     unused_in;

   assign unused_in = ^{bus.in_addr_i[LINE_ALIGN-1:0], bus.in_set_i};

   // Line compare of the incoming address against every live entry.
   always_comb begin
      in_line   = bus.in_addr_i[FETCH_AW-1:LINE_ALIGN];
      match     = 1'b0;
      match_idx = '0;
      for (int unsigned i = 0; i < PENDING_COUNT; i++) begin
         pend_valid[i] = pend_q[i].valid;
         if (pend_q[i].valid && (pend_q[i].line == in_line)) begin
            match     = 1'b1;
            match_idx = PID_WIDTH'(i);
         end
      end
   end

   lzc #(
      .WIDTH (PENDING_COUNT),
      .MODE  (1'b0)
   ) i_free_lzc (
      .in_i    (~pend_valid),
      .cnt_o   (free_idx),
      .empty_o (no_free)
   );

   // Handshake decisions; a returning refill owns the response port outright.
   always_comb begin
      cpl         = pend_q[bus.refill_pid_i];
      complete_en = bus.refill_valid_i && bus.write_ready_i && bus.rsp_ready_i;
      merge_en    = 1'b0;
      alloc_en    = 1'b0;
      bus.in_ready_o = 1'b0;
      if (bus.in_valid_i) begin
         if (bus.in_hit_i) begin
            bus.in_ready_o = !bus.refill_valid_i && bus.rsp_ready_i;
         end else if (match) begin
            // Merging into an entry that is being cleared this edge would lose the ID.
            merge_en       = !(complete_en && (bus.refill_pid_i == match_idx));
            bus.in_ready_o = merge_en;
         end else begin
            alloc_en       = !no_free && !refill_valid_q;
            bus.in_ready_o = alloc_en;
         end
      end
      bus.flush_ready_o = ~|pend_valid && !refill_valid_q;
      flush_fire        = bus.flush_valid_i && bus.flush_ready_o;
   end

   // Response, write-back and refill request drive.
   always_comb begin
      rsp_data        = bus.in_data_i;
      rsp_id          = bus.in_id_i;
      bus.rsp_error_o = bus.in_error_i;
      bus.rsp_valid_o = bus.in_valid_i && bus.in_hit_i;
      if (bus.refill_valid_i) begin
         rsp_data        = bus.refill_data_i;
         rsp_id          = cpl.idmask;
         bus.rsp_error_o = bus.refill_error_i;
         bus.rsp_valid_o = complete_en;
      end
      bus.rsp_data_o     = rsp_data;
      bus.rsp_id_o       = rsp_id;

      bus.refill_ready_o = complete_en;
      bus.write_valid_o  = complete_en;
      bus.write_addr_o   = cpl.line[COUNT_ALIGN-1:0];
      bus.write_tag_o    = TAG_WIDTH'(cpl.line[LINE_AW-1:COUNT_ALIGN]);
      bus.write_set_o    = cpl.set;
      bus.write_data_o   = bus.refill_data_i;
      bus.write_error_o  = bus.refill_error_i;

      bus.refill_valid_o = refill_valid_q;
      bus.refill_addr_o  = {refill_line_q, {LINE_ALIGN{1'b0}}};
      bus.refill_pid_o   = refill_pid_q;
   end

   // Pending table: clear on completion, merge IDs, allocate fresh misses.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < PENDING_COUNT; i++) begin
            pend_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < PENDING_COUNT; i++) begin
            if (complete_en && (bus.refill_pid_i == PID_WIDTH'(i))) begin
               pend_q[i].valid <= 1'b0;
            end
            if (merge_en && (match_idx == PID_WIDTH'(i))) begin
               pend_q[i].idmask <= pend_q[i].idmask | bus.in_id_i;
            end
            if (alloc_en && (free_idx == PID_WIDTH'(i))) begin
               pend_q[i] <= '{valid: 1'b1, line: in_line, set: victim_q, idmask: bus.in_id_i};
            end
         end
      end
   end

   // Victim set counter and the outstanding refill request register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         victim_q       <= '0;
         refill_valid_q <= 1'b0;
         refill_line_q  <= '0;
         refill_pid_q   <= '0;
      end else begin
         if (flush_fire) begin
            victim_q <= '0;
         end else if (alloc_en) begin
            victim_q <= victim_q + 1'b1;
         end
         if (alloc_en) begin
            refill_valid_q <= 1'b1;
            refill_line_q  <= in_line;
            refill_pid_q   <= free_idx;
         end else if (bus.refill_ready_i) begin
            refill_valid_q <= 1'b0;
         end
      end
   end

   refill_pid_valid_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.refill_valid_i |-> pend_valid[bus.refill_pid_i]);

endmodule
